// File: rtl/nespc_ppu_capture.sv
// nespc_ppu_capture: records completed PPU register accesses seen on the CPU
// bus as {RW, REG, DATA} events and queues them in a small first-word
// fall-through FIFO for the host-side PPU shadow logic. M2 is asynchronous to
// SYSCLK; it is synchronized, and the bus is delayed by the same number of
// flops, so the event is taken from the last sample seen with M2 high.
module nespc_ppu_capture #(
    parameter int DEPTH         = 8,
    parameter bit CAPTURE_READS = 1'b1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                    SYSCLK,
    input  logic                    nRESET,
    input  logic                    M2,
    input  logic [2:0]              CPU_A,
    input  logic [7:0]              CPU_D,
    input  logic                    CPU_RW,
    input  logic                    PPU_nCE,
    output logic                    EV_VALID,
    input  logic                    EV_READY,
    output logic                    EV_RW,
    output logic [2:0]              EV_REG,
    output logic [7:0]              EV_DATA,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic                    OVERFLOW,
    input  logic                    OVF_CLR
);
    localparam int AW         = $clog2(DEPTH);
    localparam int BUS_STAGES = SYNC_STAGES + 1;
    localparam logic [AW:0] LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic       nce;
        logic       rw;
        logic [2:0] a;
        logic [7:0] d;
    } bus_t;

    typedef struct packed {
        logic       rw;
        logic [2:0] reg_idx;
        logic [7:0] data;
    } event_t;

    logic [SYNC_STAGES-1:0] m2_sync;
    logic                   m2_s;
    logic                   m2_d;
    bus_t                   bus_pipe [BUS_STAGES];
    bus_t                   bus_d;

    event_t                 mem [DEPTH];
    event_t                 head;
    event_t                 head_next;
    event_t                 push_ev;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          rd_ptr_inc;

    logic                   strobe;
    logic                   push_req;
    logic                   do_push;
    logic                   do_pop;
    logic                   drop;
    logic                   full;

    assign m2_s  = m2_sync[SYNC_STAGES-1];
    assign bus_d = bus_pipe[BUS_STAGES-1];

    // M2 synchronizer plus one extra flop for falling-edge detection; the bus
    // pipeline has the same depth so bus_d lines up with m2_d.
    // NOTE: every clocked block uses non-blocking (<=) assignments so that all
    // flops sample the pre-edge values; blocking here would collapse the chain.
    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            m2_sync <= '0;
            m2_d    <= 1'b0;
            for (int i = 0; i < BUS_STAGES; i++) bus_pipe[i] <= '0;
        end else begin
            m2_sync     <= {m2_sync[SYNC_STAGES-2:0], M2};
            m2_d        <= m2_s;
            bus_pipe[0] <= {PPU_nCE, CPU_RW, CPU_A, CPU_D};
            for (int i = 1; i < BUS_STAGES; i++) bus_pipe[i] <= bus_pipe[i-1];
        end
    end

    // Falling M2 ends a bus cycle; qualify it against chip enable and direction.
    assign strobe   = !m2_s && m2_d;
    assign push_req = strobe && !bus_d.nce && (CAPTURE_READS || !bus_d.rw);
    assign push_ev  = '{rw: bus_d.rw, reg_idx: bus_d.a, data: bus_d.d};

    assign full       = (LEVEL == LEVEL_FULL);
    assign EV_VALID   = (LEVEL != '0);
    assign do_pop     = EV_VALID && EV_READY;
    assign do_push    = push_req && (!full || do_pop);
    assign drop       = push_req && full && !do_pop;
    assign rd_ptr_inc = rd_ptr + 1'b1;

    // Event storage, written at the tail on every accepted push.
    // NOTE: the storage array has no reset; validity is tracked by LEVEL, and
    // leaving it out of reset lets it map onto plain RAM/register-file cells.
    always_ff @(posedge SYSCLK) begin
        if (do_push) mem[wr_ptr] <= push_ev;
    end

    // Next head value: the following entry after a pop, or the incoming event
    // when it becomes the only entry; otherwise the last head is held.
    // NOTE: head_next is given a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        head_next = head;
        if (do_pop) begin
            if (LEVEL == LEVEL_ONE && do_push) head_next = push_ev;
            else if (LEVEL > LEVEL_ONE)        head_next = mem[rd_ptr_inc];
        end else if (!EV_VALID && do_push) begin
            head_next = push_ev;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            LEVEL  <= '0;
            head   <= '0;
        end else begin
            head <= head_next;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr_inc;
            case ({do_push, do_pop})
                2'b10:   LEVEL <= LEVEL + 1'b1;
                2'b01:   LEVEL <= LEVEL - 1'b1;
                default: LEVEL <= LEVEL;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET)      OVERFLOW <= 1'b0;
        else if (drop)    OVERFLOW <= 1'b1;
        else if (OVF_CLR) OVERFLOW <= 1'b0;
    end

    assign EV_RW   = head.rw;
    assign EV_REG  = head.reg_idx;
    assign EV_DATA = head.data;

endmodule

// File: tb/tb_nespc_ppu_capture.sv
// Testbench for nespc_ppu_capture: two instances (reads+writes, writes only)
// share one CPU bus. Bus cycles are modelled at the transaction level; each
// completed access is pushed into per-instance expected queues and a monitor
// pops and compares whenever an instance hands over an event.
module tb_nespc_ppu_capture;
    localparam int DEPTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LW          = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic       rw;
        logic [2:0] idx;
        logic [7:0] data;
    } ev_t;

    logic          SYSCLK   = 1'b0;
    logic          nRESET   = 1'b1;
    logic          M2       = 1'b0;
    logic [2:0]    CPU_A    = '0;
    logic [7:0]    CPU_D    = '0;
    logic          CPU_RW   = 1'b1;
    logic          PPU_nCE  = 1'b1;
    logic          EV_READY = 1'b0;
    logic          OVF_CLR  = 1'b0;
    logic          w_ready  = 1'b1;

    logic          ev_valid, ev_rw, overflow;
    logic [2:0]    ev_reg;
    logic [7:0]    ev_data;
    logic [LW-1:0] level;
    logic          w_valid, w_rw, w_overflow;
    logic [2:0]    w_reg;
    logic [7:0]    w_data;
    logic [LW-1:0] w_level;

    ev_t exp_q[$];
    ev_t exp_w_q[$];
    bit  exp_ovf    = 1'b0;
    bit  rand_ready = 1'b0;
    int  n_checks   = 0;
    int  n_pass     = 0;

    nespc_ppu_capture #(.DEPTH(DEPTH), .CAPTURE_READS(1'b1), .SYNC_STAGES(SYNC_STAGES)) dut (
        .SYSCLK(SYSCLK), .nRESET(nRESET), .M2(M2), .CPU_A(CPU_A), .CPU_D(CPU_D),
        .CPU_RW(CPU_RW), .PPU_nCE(PPU_nCE), .EV_VALID(ev_valid), .EV_READY(EV_READY),
        .EV_RW(ev_rw), .EV_REG(ev_reg), .EV_DATA(ev_data), .LEVEL(level),
        .OVERFLOW(overflow), .OVF_CLR(OVF_CLR)
    );

    nespc_ppu_capture #(.DEPTH(DEPTH), .CAPTURE_READS(1'b0), .SYNC_STAGES(SYNC_STAGES)) dut_w (
        .SYSCLK(SYSCLK), .nRESET(nRESET), .M2(M2), .CPU_A(CPU_A), .CPU_D(CPU_D),
        .CPU_RW(CPU_RW), .PPU_nCE(PPU_nCE), .EV_VALID(w_valid), .EV_READY(w_ready),
        .EV_RW(w_rw), .EV_REG(w_reg), .EV_DATA(w_data), .LEVEL(w_level),
        .OVERFLOW(w_overflow), .OVF_CLR(OVF_CLR)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Advance n clocks; inputs always change 2 ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge SYSCLK);
            #2;
            if (rand_ready) EV_READY = 1'($urandom_range(0, 1));
        end
    endtask

    // Start a CPU access: drive the bus during M2 low, then hold M2 high.
    task automatic cpu_begin(input logic rw, input logic [2:0] a, input logic [7:0] d,
                             input logic nce, input int high);
        CPU_RW  = rw;
        CPU_A   = a;
        CPU_D   = d;
        PPU_nCE = nce;
        tick(2);
        M2 = 1'b1;
        tick(high);
    endtask

    // End the access: the reference model records what a PPU access logger
    // must see (bus contents while M2 was high), then M2 falls and the bus is
    // immediately scrambled to an unselected state. pop_now tells the model
    // the consumer takes an entry in the same cycle the event arrives.
    task automatic cpu_end(input bit pop_now);
        ev_t e;
        e = '{rw: CPU_RW, idx: CPU_A, data: CPU_D};
        if (!PPU_nCE) begin
            if (exp_q.size() < DEPTH || pop_now) exp_q.push_back(e);
            else exp_ovf = 1'b1;
            if (!CPU_RW) exp_w_q.push_back(e);
        end
        M2      = 1'b0;
        PPU_nCE = 1'b1;
        CPU_D   = ~CPU_D;
        CPU_A   = 3'($urandom);
        CPU_RW  = 1'($urandom);
    endtask

    task automatic cpu_cycle(input logic rw, input logic [2:0] a, input logic [7:0] d,
                             input logic nce);
        cpu_begin(rw, a, d, nce, 5);
        cpu_end(1'b0);
        tick(6);
    endtask

    // Accept everything queued, bounded; leftovers mean missing events.
    task automatic drain(input string name);
        rand_ready = 1'b0;
        EV_READY   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (level == '0 && exp_q.size() == 0 && exp_w_q.size() == 0) break;
            tick(1);
        end
        check({name, "_level"}, level, 0);
        check({name, "_missing"}, exp_q.size(), 0);
        check({name, "_w_missing"}, exp_w_q.size(), 0);
        EV_READY = 1'b0;
        tick(1);
    endtask

    // Monitor: pop and compare on every handshake of either instance.
    always @(negedge SYSCLK) begin
        ev_t e;
        if (nRESET) begin
            if (ev_valid && EV_READY) begin
                check("event_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ev_head", {ev_rw, ev_reg, ev_data}, e);
                end
            end
            if (w_valid && w_ready) begin
                check("w_event_expected", exp_w_q.size() != 0, 1);
                if (exp_w_q.size() != 0) begin
                    e = exp_w_q.pop_front();
                    check("w_ev_head", {w_rw, w_reg, w_data}, e);
                end
            end
        end
    end

    initial begin
        int lat;
        #3 nRESET = 1'b0;
        tick(2);
        check("reset_valid", ev_valid, 0);
        check("reset_level", level, 0);
        check("reset_overflow", overflow, 0);
        check("reset_head", {ev_rw, ev_reg, ev_data}, 0);
        nRESET = 1'b1;
        tick(3);

        // $2006 <= $3F, $2006 <= $00
        cpu_begin(1'b0, 3'd6, 8'h3F, 1'b0, 5);
        check("valid_before_fall", ev_valid, 0);
        cpu_end(1'b0);
        lat = 0;
        for (int k = 1; k <= SYNC_STAGES + 5; k++) begin
            tick(1);
            if (ev_valid) begin
                lat = k;
                break;
            end
        end
        check("latency_seen", ev_valid, 1);
        check("latency_window", (lat >= SYNC_STAGES && lat <= SYNC_STAGES + 2), 1);
        tick(5);
        check("t1_level1", level, 1);
        cpu_cycle(1'b0, 3'd6, 8'h00, 1'b0);
        check("t1_level2", level, 2);
        check("t1_overflow", overflow, 0);
        drain("t1");

        // Read $2002 = $80: logged only by the read-capturing instance
        cpu_cycle(1'b1, 3'd2, 8'h80, 1'b0);
        check("t2_level", level, 1);
        check("t2_w_level", w_level, 0);
        drain("t2");

        // Nine writes to $2007 into an 8-deep FIFO with no consumer
        for (int i = 0; i < 9; i++) cpu_cycle(1'b0, 3'd7, 8'(i), 1'b0);
        check("t3_level", level, DEPTH);
        check("t3_overflow", overflow, exp_ovf);
        check("t3_head", ev_data, exp_q[0].data);
        OVF_CLR = 1'b1;
        tick(1);
        OVF_CLR = 1'b0;
        exp_ovf = 1'b0;
        check("t3_ovf_clr", overflow, exp_ovf);

        // Drop coinciding with OVF_CLR: the set wins
        cpu_begin(1'b0, 3'd7, 8'h55, 1'b0, 5);
        cpu_end(1'b0);
        tick(2);
        OVF_CLR = 1'b1;
        tick(1);
        OVF_CLR = 1'b0;
        tick(3);
        check("t3_set_wins", overflow, exp_ovf);
        OVF_CLR = 1'b1;
        tick(1);
        OVF_CLR = 1'b0;
        exp_ovf = 1'b0;
        check("t3_ovf_clr2", overflow, exp_ovf);

        // Full FIFO, consumer takes the head in the cycle the event arrives
        cpu_begin(1'b0, 3'd7, 8'hA5, 1'b0, 5);
        cpu_end(1'b1);
        tick(2);
        EV_READY = 1'b1;
        tick(1);
        EV_READY = 1'b0;
        tick(3);
        check("t4_level", level, DEPTH);
        check("t4_overflow", overflow, 0);
        drain("t4");

        // Deselected accesses ($0000, $4038) and data settling during M2 high
        cpu_cycle(1'b0, 3'd0, 8'h12, 1'b1);
        cpu_cycle(1'b0, 3'd0, 8'h34, 1'b1);
        check("t5_no_event", level, 0);
        check("t5_w_no_event", w_level, 0);
        cpu_begin(1'b0, 3'd7, 8'h11, 1'b0, 3);
        CPU_D = 8'h22;
        tick(3);
        cpu_end(1'b0);
        tick(6);
        check("t5_level", level, 1);
        drain("t5");

        // Randomized traffic with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cpu_begin(1'($urandom), 3'($urandom), 8'($urandom),
                      ($urandom_range(0, 3) == 0), $urandom_range(1, 6));
            cpu_end(1'b0);
            tick($urandom_range(3, 8));
        end
        drain("rand");
        check("rand_overflow", overflow, exp_ovf);

        // Reset mid-access with three entries queued
        for (int i = 1; i <= 3; i++) cpu_cycle(1'b0, 3'd0, 8'(i), 1'b0);
        check("t6_level_before", level, 3);
        cpu_begin(1'b0, 3'd5, 8'h77, 1'b0, 3);
        nRESET = 1'b0;
        #1;
        check("t6_valid_async", ev_valid, 0);
        check("t6_level_async", level, 0);
        exp_q.delete();
        exp_w_q.delete();
        exp_ovf = 1'b0;
        tick(2);
        M2 = 1'b0;
        tick(3);
        nRESET = 1'b1;
        tick(12);
        check("t6_discarded", level, 0);
        check("t6_w_discarded", w_level, 0);
        cpu_cycle(1'b0, 3'd5, 8'h78, 1'b0);
        check("t6_first_after", level, 1);
        drain("t6");

        check("final_overflow", overflow, exp_ovf);
        check("final_w_overflow", w_overflow, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
